// File: rtl/jacobi_result_reader_pkg.sv
// Shared Jacobi solver constants and types for the result read-out path.
package jacobi_result_reader_pkg;

    localparam int unsigned JACOBI_N                  = 8;
    localparam int unsigned JACOBI_OUTPUT_WORD_WIDTH  = 20;
    localparam int unsigned JACOBI_ADDR_WIDTH         = 7;
    localparam int unsigned JACOBI_V_OFFSET           = 36;
    localparam int unsigned JACOBI_N_OUTPUT_DATA      = 72;
    localparam int unsigned JACOBI_LOG2_N_OUTPUT_DATA = 7;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StFin
    } reader_state_e;

    typedef struct packed {
        logic [JACOBI_OUTPUT_WORD_WIDTH-1:0] data;
        logic                                is_vec;
        logic                                last;
    } out_beat_t;

endpackage

// File: rtl/jacobi_skid_fifo.sv
// Two-entry FIFO of output beats; push into a full FIFO or pop from an empty one is dropped.
module jacobi_skid_fifo
    import jacobi_result_reader_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  out_beat_t  data_i,
    input  logic       pop_i,
    output out_beat_t  data_o,
    output logic [1:0] count_o,
    output logic       full_o,
    output logic       empty_o
);

    out_beat_t  mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       push_ok;
    logic       pop_ok;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= !wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/jacobi_result_reader.sv
// Drains eigenvalues (packed diagonal) then eigenvectors from Jacobi working memory
// onto a valid/ready stream, with read credits bounding reads in flight plus buffered beats.
module jacobi_result_reader
    import jacobi_result_reader_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = JACOBI_OUTPUT_WORD_WIDTH,
    parameter int unsigned N          = JACOBI_N,
    parameter int unsigned ADDR_WIDTH = JACOBI_ADDR_WIDTH,
    parameter int unsigned V_OFFSET   = JACOBI_V_OFFSET
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [WORD_WIDTH-1:0] mem_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_is_vec,
    output logic                  out_last
);

    localparam int unsigned IdxW = JACOBI_LOG2_N_OUTPUT_DATA;
    localparam logic [IdxW-1:0]       NumDiag = IdxW'(N);
    localparam logic [IdxW-1:0]       LastIdx = IdxW'(JACOBI_N_OUTPUT_DATA - 1);
    localparam logic [ADDR_WIDTH-1:0] NAddr   = ADDR_WIDTH'(N);
    localparam logic [ADDR_WIDTH-1:0] VBase   = ADDR_WIDTH'(V_OFFSET);

    reader_state_e         state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_vec_q, inflight_vec_d;
    logic                  inflight_last_q, inflight_last_d;

    out_beat_t  in_beat;
    out_beat_t  head_beat;
    out_beat_t  out_beat;
    logic       fifo_push;
    logic       fifo_pop;
    logic [1:0] fifo_count;
    logic       fifo_full;
    logic       fifo_empty;
    logic       hs;
    logic [1:0] occ;

    assign in_beat = '{data: mem_rd_data, is_vec: inflight_vec_q, last: inflight_last_q};

    // Returning data bypasses the FIFO when it is empty so first data is valid with no extra cycle.
    assign out_valid = !fifo_empty || inflight_q;
    assign out_beat  = (fifo_empty && inflight_q) ? in_beat : head_beat;
    assign hs        = out_valid && out_ready;
    assign fifo_pop  = out_ready && !fifo_empty;
    assign fifo_push = inflight_q && !(fifo_empty && out_ready);

    // Slots already claimed once this cycle's pop is counted; in-flight data counts as claimed.
    assign occ = fifo_count + {1'b0, inflight_q} - {1'b0, hs};

    assign out_data    = out_beat.data;
    assign out_is_vec  = out_beat.is_vec;
    assign out_last    = out_beat.last;
    assign mem_rd_addr = addr_q;

    jacobi_skid_fifo u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (fifo_push),
        .data_i  (in_beat),
        .pop_i   (fifo_pop),
        .data_o  (head_beat),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        addr_d          = addr_q;
        inflight_d      = 1'b0;
        inflight_vec_d  = inflight_vec_q;
        inflight_last_d = inflight_last_q;
        mem_rd_en       = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRead;
                    idx_d   = '0;
                    addr_d  = '0;
                end
            end
            StRead: begin
                busy = 1'b1;
                if (occ < 2'd2) begin
                    mem_rd_en       = 1'b1;
                    inflight_d      = 1'b1;
                    inflight_vec_d  = (idx_q >= NumDiag);
                    inflight_last_d = (idx_q == LastIdx);
                    idx_d           = idx_q + IdxW'(1);
                    // Diagonal stride shrinks by one per row of the packed upper triangle.
                    if (idx_q == NumDiag - IdxW'(1)) begin
                        addr_d = VBase;
                    end else if (idx_q < NumDiag) begin
                        addr_d = addr_q + NAddr - ADDR_WIDTH'(idx_q);
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                    if (idx_q == LastIdx) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                busy = 1'b1;
                if (hs && out_last) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            idx_q           <= '0;
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_vec_q  <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            addr_q          <= addr_d;
            inflight_q      <= inflight_d;
            inflight_vec_q  <= inflight_vec_d;
            inflight_last_q <= inflight_last_d;
        end
    end

endmodule

// File: doc/jacobi_result_reader.md
Name: jacobi_result_reader

Overview:
- Drains solver results from the Jacobi working memory after a run completes; it is the read-side counterpart of the input loader that writes the 36 packed upper-triangle words.
- Issues reads on the memory's 1-cycle-latency read port.
- Streams 8 eigenvalues (the diagonal of the packed triangle), then the 64 eigenvector entries of V (row-major), over a valid/ready stream with backpressure.
- Sits between the Jacobi core memory and the output DMA/host interface.

Parameters:
- WORD_WIDTH, default 20 (JACOBI_OUTPUT_WORD_WIDTH): data width, Q(1.4.15).
- N, default 8 (JACOBI_N): matrix dimension.
- ADDR_WIDTH, default 7 (JACOBI_ADDR_WIDTH): memory address width.
- V_OFFSET, default 36 (JACOBI_V_OFFSET): base address of V.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  one-cycle pulse; begins a drain when idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the final beat is accepted.
- mem_rd_en  out  1  memory read enable.
- mem_rd_addr  out  ADDR_WIDTH  read address.
- mem_rd_data  in  WORD_WIDTH  read data, valid the cycle after mem_rd_en.
- out_valid  out  1  stream data valid.
- out_ready  in  1  downstream accept.
- out_data  out  WORD_WIDTH  stream payload.
- out_is_vec  out  1  0 = eigenvalue beat, 1 = V beat.
- out_last  out  1  high on beat 71 (final V entry).

Behaviour:
- Reset values: busy=0, done=0, mem_rd_en=0, mem_rd_addr=0, out_valid=0, out_data=0, out_is_vec=0, out_last=0. Buffer is emptied, counters are cleared, FSM goes to IDLE.
- FSM states:
  - IDLE: on start go to READ.
  - READ: issue reads.
  - DRAIN: all 72 reads issued; wait for the buffer to empty.
  - FIN: assert done for 1 cycle, then go to IDLE.
- Read sequence index k=0..71:
  - k<8: address DIAG(k) = k*N - k*(k-1)/2, giving 0,8,15,21,26,30,33,35.
  - k>=8: address V_OFFSET + (k-8), giving 36..99.
  - DIAG is computed by an incremental adder (step N-k), not a multiplier.
- Flow control: a 2-entry output FIFO plus an in-flight read flag.
  - A read is issued in a cycle only if (fifo_count + inflight) < 2, counted after that cycle's pop.
  - This guarantees no data loss under any out_ready pattern.
- Throughput: with out_ready held high, exactly 1 beat per cycle.
  - First out_valid arrives 2 cycles after the start cycle (start in cycle 0, rd_en in cycle 1, data and valid in cycle 2).
  - Beat 71 appears in cycle 73.
  - done pulses in the cycle after the beat-71 handshake.
- Stream rules:
  - out_data, out_is_vec and out_last are held stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a handshake.
  - out_is_vec and out_last travel in the FIFO with the data.
- Boundaries:
  - start while busy: ignored.
  - start coincident with rst: rst wins.
  - rst mid-drain: the stream is aborted immediately, out_valid goes to 0 next cycle, and no done.
  - A simultaneous FIFO push and pop when full is not possible by the credit rule. When count=1, push and pop together leave count=1.
- No arithmetic on the data path: the word passes through unchanged, and the sign is preserved.

Decomposition:
- Add to shared package:
  - JACOBI_N_OUTPUT_DATA=72
  - JACOBI_LOG2_N_OUTPUT_DATA=7
  - a typedef enum for reader states {IDLE, READ, DRAIN, FIN}
  - a packed struct out_beat_t {data, is_vec, last}
- One sub-module: jacobi_skid_fifo, a 2-deep FIFO of out_beat_t with push/pop, count, full and empty. It is reusable for the input side.

Test Plan:
- Memory preloaded with mem[a]=a+1000 (sign-extended, 20-bit); start with out_ready=1.
  - Required: 72 beats on consecutive cycles, first beat in cycle 2.
  - Eigenvalue beats: data 1000,1008,1015,1021,1026,1030,1033,1035 with is_vec=0.
  - V beats: then 1036..1099 with is_vec=1.
  - last only on the 1099 beat; done one cycle later.
- Random out_ready at 30% duty.
  - Required: the same 72-value sequence with no drops or duplicates.
  - Data stable during stalls; never more than 2 reads outstanding plus buffered.
- out_ready=0 for 20 cycles after start.
  - Required: exactly 2 reads issued, out_valid=1 holding 1000; on release, the stream resumes in order.
- Negative value: mem[0]=20'hFFFFF (-1/32768).
  - Required: beat 0 data 20'hFFFFF unchanged.
- Second start pulse in cycle 10 of a drain.
  - Required: ignored, total beats 72, a single done.
- rst asserted at beat 40.
  - Required: out_valid=0 and busy=0 next cycle, no done.
  - A new start then produces the full sequence from 1000.
